// File: rtl/led_mode_sequencer_if.sv
// Pin-level bundle between the board switch/LED pins and the LED mode sequencer.
// The sequencer takes the slave side; the board (or a bench) takes the master side.
interface led_mode_sequencer_if;
   logic       i_Switch_1;
   logic       o_LED_1;
   logic       o_LED_2;
   logic       o_LED_3;
   logic       o_LED_4;
   logic [1:0] o_Mode;
   logic       o_Release;

   modport master (
      output i_Switch_1,
      input  o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode, o_Release
   );

   modport slave (
      input  i_Switch_1,
      output o_LED_1, o_LED_2, o_LED_3, o_LED_4, o_Mode, o_Release
   );
endinterface

// File: rtl/led_mode_sequencer.sv
// Debounced push-button release steps the four user LEDs through
// OFF / ALL_ON / BLINK / CHASE, with a shared rate counter timing the patterns.
module led_mode_sequencer #(
   parameter int DEBOUNCE_LIMIT = 250000,
   parameter int RATE_LIMIT     = 12500000
) (
   input logic                 i_Clk,
   input logic                 i_Rst_L,
   led_mode_sequencer_if.slave bus
);

   localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
   localparam int RT_W = $clog2(RATE_LIMIT);
   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
   localparam logic [RT_W-1:0] RATE_LAST = RT_W'(RATE_LIMIT - 1);

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_ALL_ON = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_CHASE  = 2'd3
   } mode_e;

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            stable_q, stable_d;
   logic            prev_q;
   logic            release_q;

   mode_e           mode_q, mode_d;
   logic [RT_W-1:0] rate_q, rate_d;
   logic [3:0]      leds_q, leds_d;
   logic            tick;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      db_cnt_d = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (db_cnt_q == DB_LAST) stable_d = sync2_q;
         else                     db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         stable_q  <= 1'b0;
         prev_q    <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= bus.i_Switch_1;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         stable_q  <= stable_d;
         prev_q    <= stable_q;
         release_q <= prev_q & ~stable_q;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         mode_q <= MODE_OFF;
         rate_q <= '0;
         leds_q <= 4'b0000;
      end else begin
         mode_q <= mode_d;
         rate_q <= rate_d;
         leds_q <= leds_d;
      end
   end

   assign tick = (rate_q == RATE_LAST);

   always_comb begin
      mode_d = mode_q;
      if (release_q) begin
         unique case (mode_q)
            MODE_OFF:    mode_d = MODE_ALL_ON;
            MODE_ALL_ON: mode_d = MODE_BLINK;
            MODE_BLINK:  mode_d = MODE_CHASE;
            MODE_CHASE:  mode_d = MODE_OFF;
         endcase
      end

      if (release_q || tick) rate_d = '0;
      else                   rate_d = rate_q + RT_W'(1);
   end

   // A mode change outranks a coincident tick: the entry pattern loads instead of a step.
   always_comb begin
      leds_d = leds_q;
      if (release_q) begin
         unique case (mode_d)
            MODE_OFF:    leds_d = 4'b0000;
            MODE_ALL_ON: leds_d = 4'b1111;
            MODE_BLINK:  leds_d = 4'b1111;
            MODE_CHASE:  leds_d = 4'b0001;
         endcase
      end else if (tick) begin
         unique case (mode_q)
            MODE_BLINK: leds_d = ~leds_q;
            MODE_CHASE: leds_d = {leds_q[2:0], leds_q[3]};
            default:    leds_d = leds_q;
         endcase
      end
   end

   assign bus.o_Mode    = mode_q;
   assign bus.o_Release = release_q;
   assign bus.o_LED_1   = leds_q[0];
   assign bus.o_LED_2   = leds_q[1];
   assign bus.o_LED_3   = leds_q[2];
   assign bus.o_LED_4   = leds_q[3];

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed scenarios plus random switch activity,
// every cycle compared against a cycle-count reference model.
module tb_led_mode_sequencer;

   localparam int DB = 4;
   localparam int RL = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   rel_count;

   led_mode_sequencer_if bus ();

   led_mode_sequencer #(
      .DEBOUNCE_LIMIT (DB),
      .RATE_LIMIT     (RL)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: switch delay line, mismatch run length, release pulse,
   // mode number and cycles elapsed since the last mode entry.
   bit m_s0, m_s1, m_stable, m_prev, m_rel;
   int m_run, m_mode, m_elapsed;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_leds();
      int steps;
      steps = m_elapsed / RL;
      case (m_mode)
         1:       return 4'b1111;
         2:       return (steps % 2 == 0) ? 4'b1111 : 4'b0000;
         3:       return 4'(1 << (steps % 4));
         default: return 4'b0000;
      endcase
   endfunction

   task automatic model_reset();
      m_s0 = 0; m_s1 = 0; m_stable = 0; m_prev = 0; m_rel = 0;
      m_run = 0; m_mode = 0; m_elapsed = 0;
   endtask

   task automatic model_edge(input bit sw);
      bit sync_pre, stable_pre, rel_pre;
      sync_pre   = m_s1;
      stable_pre = m_stable;
      rel_pre    = m_rel;
      if (sync_pre != m_stable) begin
         m_run++;
         if (m_run == DB) begin
            m_stable = sync_pre;
            m_run    = 0;
         end
      end else begin
         m_run = 0;
      end
      m_rel  = m_prev & ~stable_pre;
      m_prev = stable_pre;
      if (rel_pre) begin
         m_mode    = (m_mode + 1) % 4;
         m_elapsed = 0;
      end else begin
         m_elapsed++;
      end
      m_s1 = m_s0;
      m_s0 = sw;
   endtask

   function automatic logic [3:0] dut_leds();
      return {bus.o_LED_4, bus.o_LED_3, bus.o_LED_2, bus.o_LED_1};
   endfunction

   task automatic compare_model();
      check("mode", 8'(bus.o_Mode), 8'(m_mode));
      check("release", 8'(bus.o_Release), 8'(m_rel));
      check("leds", 8'(dut_leds()), 8'(exp_leds()));
   endtask

   task automatic cycle(input bit sw);
      bus.i_Switch_1 = sw;
      @(posedge clk);
      model_edge(sw);
      #1;
      compare_model();
      rel_count += int'(bus.o_Release);
   endtask

   task automatic press_release(input int hi, input int lo);
      repeat (hi) cycle(1'b1);
      repeat (lo) cycle(1'b0);
   endtask

   // Reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_mode", 8'(bus.o_Mode), 8'd0);
      check("rst_leds", 8'(dut_leds()), 8'd0);
      check("rst_release", 8'(bus.o_Release), 8'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      bit lvl;
      checks    = 0;
      errors    = 0;
      rel_count = 0;
      rst_n     = 1'b1;
      bus.i_Switch_1 = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Bounce rejection: 2-cycle pulses never outlast the debounce window.
      rel_count = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(i % 2 == 0);
         cycle(i % 2 == 0);
      end
      repeat (10) cycle(1'b0);
      check("bounce_rel_cnt", 8'(rel_count), 8'd0);
      check("bounce_mode", 8'(bus.o_Mode), 8'd0);

      // Clean press then release: only the release produces an event.
      rel_count = 0;
      repeat (10) cycle(1'b1);
      check("press_no_rel", 8'(rel_count), 8'd0);
      repeat (10) cycle(1'b0);
      check("clean_rel_cnt", 8'(rel_count), 8'd1);
      check("clean_mode", 8'(bus.o_Mode), 8'd1);
      check("clean_leds", 8'(dut_leds()), 8'hf);

      // Remaining mode steps with entry patterns.
      press_release(10, 10);
      check("cyc_mode2", 8'(bus.o_Mode), 8'd2);
      check("cyc_leds2", 8'(dut_leds()), 8'hf);
      press_release(10, 10);
      check("cyc_mode3", 8'(bus.o_Mode), 8'd3);
      check("cyc_leds3", 8'(dut_leds()), 8'h1);
      press_release(10, 10);
      check("cyc_mode0", 8'(bus.o_Mode), 8'd0);
      check("cyc_leds0", 8'(dut_leds()), 8'h0);

      // BLINK timing: the 8th low cycle is exactly the mode-change edge.
      press_release(10, 10);
      press_release(10, 8);
      check("blink_entry_mode", 8'(bus.o_Mode), 8'd2);
      check("blink_entry", 8'(dut_leds()), 8'hf);
      repeat (8) cycle(1'b0);
      check("blink_8", 8'(dut_leds()), 8'h0);
      repeat (8) cycle(1'b0);
      check("blink_16", 8'(dut_leds()), 8'hf);

      // Collision: time the release so the mode-change edge is also a tick edge.
      repeat (10) cycle(1'b1);
      found = 1'b0;
      for (int i = 0; i < RL && !found; i++) begin
         if ((m_elapsed + DB + 4) % RL == 0) found = 1'b1;
         else cycle(1'b1);
      end
      check("collide_align", 8'(found), 8'd1);
      repeat (DB + 4) cycle(1'b0);
      check("collide_mode", 8'(bus.o_Mode), 8'd3);
      check("collide_leds", 8'(dut_leds()), 8'h1);
      repeat (RL - 1) cycle(1'b0);
      check("chase_hold7", 8'(dut_leds()), 8'h1);
      cycle(1'b0);
      check("chase_8", 8'(dut_leds()), 8'h2);
      repeat (RL) cycle(1'b0);
      check("chase_16", 8'(dut_leds()), 8'h4);
      repeat (RL) cycle(1'b0);
      check("chase_24", 8'(dut_leds()), 8'h8);
      repeat (RL) cycle(1'b0);
      check("chase_32", 8'(dut_leds()), 8'h1);

      // Reset in the middle of CHASE while 0100 is showing.
      repeat (2 * RL) cycle(1'b0);
      check("chase_pre_rst", 8'(dut_leds()), 8'h4);
      do_reset();
      cycle(1'b0);
      check("post_rst_mode", 8'(bus.o_Mode), 8'd0);

      // Random switch activity with occasional resets, checked every cycle.
      for (int seg = 0; seg < 300; seg++) begin
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0) do_reset();
         repeat ($urandom_range(1, 14)) cycle(lvl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
